alu_issue_ctrl: RTL and testbench

//  Initiator side of the 16-bit ALU operand/result interface (a, b, op -> out, r15, of).

---
 rtl/alu_issue_ctrl_pkg.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: op codes, FSM states, helpers.
// Pure declarations, no logic latency.
// No flow control lives here.
package alu_issue_ctrl_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_OPW   = 3;

  // Assigned op codes; 3'b111 is the single unassigned encoding.
  localparam logic [2:0] ALU_OP_0       = 3'b000;
  localparam logic [2:0] ALU_OP_1       = 3'b001;
  localparam logic [2:0] ALU_OP_2       = 3'b010;
  localparam logic [2:0] ALU_OP_3       = 3'b011;
  localparam logic [2:0] ALU_OP_4       = 3'b100;
  localparam logic [2:0] ALU_OP_5       = 3'b101;
  localparam logic [2:0] ALU_OP_6       = 3'b110;
  localparam logic [2:0] ALU_OP_ILLEGAL = 3'b111;

  // Issue FSM: accept, hold operands for the settle time, present result.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } issue_state_t;

  // True for any op code the ALU implements.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op != ALU_OP_ILLEGAL);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Initiator for the combinational ALU: registers operands, waits SETTLE cycles, returns result.
// Latency: rsp_valid SETTLE+1 cycles after accept for legal ops, 1 cycle for the illegal op.
// Backpressure: one op in flight; req_ready low until the response handshakes, rsp_* held stable.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int OPW    = 3,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_r15,
  input  logic             alu_of,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic [WIDTH-1:0] rsp_r15,
  output logic             rsp_of,
  output logic             rsp_err,
  input  logic             of_clr,
  output logic             of_sticky,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // Settle counter is 4 bits wide, enough for the 1..15 cycle range.
  localparam logic [3:0]     SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [OPW-1:0] OP_ILLEGAL  = OPW'(ALU_OP_ILLEGAL);

  issue_state_t     state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [OPW-1:0]   alu_op_q;
  logic [WIDTH-1:0] rsp_out_q, rsp_r15_q;
  logic             rsp_of_q, rsp_err_q;
  logic             of_sticky_q, of_sticky_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic req_illegal;
  logic capture_evt;
  logic rsp_hs;

  assign req_illegal = (req_op == OP_ILLEGAL);
  assign capture_evt = (state_q == ST_SETTLE) && (cnt_q == 4'd0);
  assign rsp_hs      = (state_q == ST_RESP) && rsp_ready;

  // Issue FSM with operand, settle-counter and result capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      rsp_out_q <= '0;
      rsp_r15_q <= '0;
      rsp_of_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            // Operands are driven to the ALU even for the illegal op.
            alu_a_q  <= req_a;
            alu_b_q  <= req_b;
            alu_op_q <= req_op;
            if (req_illegal) begin
              rsp_out_q <= '0;
              rsp_r15_q <= '0;
              rsp_of_q  <= 1'b0;
              rsp_err_q <= 1'b1;
              state_q   <= ST_RESP;
            end else begin
              rsp_err_q <= 1'b0;
              cnt_q     <= SETTLE_LOAD;
              state_q   <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_q == 4'd0) begin
            rsp_out_q <= alu_out;
            rsp_r15_q <= alu_r15;
            rsp_of_q  <= alu_of;
            rsp_err_q <= 1'b0;
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow: a capture with of=1 beats a simultaneous clear.
  always_comb begin
    of_sticky_d = of_sticky_q;
    if (capture_evt && alu_of) begin
      of_sticky_d = 1'b1;
    end else if (of_clr) begin
      of_sticky_d = 1'b0;
    end
  end

  // Completed-op counter: only legal responses count; wraps naturally.
  always_comb begin
    op_count_d = op_count_q;
    if (rsp_hs && !rsp_err_q) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  // Status registers; reset discards history along with any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      of_sticky_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      of_sticky_q <= of_sticky_d;
      op_count_q  <= op_count_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_r15   = rsp_r15_q;
  assign rsp_of    = rsp_of_q;
  assign rsp_err   = rsp_err_q;
  assign of_sticky = of_sticky_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an xor/and ALU stub, SETTLE=1 and SETTLE=3 instances.
// Latency checks are cycle exact, sampled 1 time unit after each rising edge.
// Response backpressure is driven explicitly through rsp_ready.
module tb_alu_issue_ctrl;

  logic        clk;
  int          n_tests = 0;
  int          n_fail  = 0;

  // SETTLE=1 instance signals
  logic        rst, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0]  req_op, alu_op;
  logic [15:0] req_a, req_b, alu_a, alu_b, alu_out, alu_r15, rsp_out, rsp_r15;
  logic        alu_of, rsp_of, rsp_err, of_clr, of_sticky, busy;
  logic [7:0]  op_count;

  // SETTLE=3 instance signals
  logic        rst3, req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [2:0]  req_op3, alu_op3;
  logic [15:0] req_a3, req_b3, alu_a3, alu_b3, alu_out3, alu_r153, rsp_out3, rsp_r153;
  logic        alu_of3, rsp_of3, rsp_err3, of_clr3, of_sticky3, busy3;
  logic [7:0]  op_count3;

  // ALU stubs
  assign alu_out  = alu_a ^ alu_b;
  assign alu_r15  = alu_a & alu_b;
  assign alu_of   = alu_a[15];
  assign alu_out3 = alu_a3 ^ alu_b3;
  assign alu_r153 = alu_a3 & alu_b3;
  assign alu_of3  = alu_a3[15];

  alu_issue_ctrl #(.WIDTH(16), .OPW(3), .SETTLE(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_r15(alu_r15), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_r15(rsp_r15), .rsp_of(rsp_of), .rsp_err(rsp_err),
    .of_clr(of_clr), .of_sticky(of_sticky), .busy(busy), .op_count(op_count)
  );

  alu_issue_ctrl #(.WIDTH(16), .OPW(3), .SETTLE(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op(req_op3), .req_a(req_a3), .req_b(req_b3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_out(alu_out3), .alu_r15(alu_r153), .alu_of(alu_of3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_out(rsp_out3),
    .rsp_r15(rsp_r153), .rsp_of(rsp_of3), .rsp_err(rsp_err3),
    .of_clr(of_clr3), .of_sticky(of_sticky3), .busy(busy3), .op_count(op_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete legal transaction on the SETTLE=1 instance, bounded wait.
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int k;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 10) begin
      tick();
      k++;
    end
    chk("do_op_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; of_clr = 1'b0;
    req_op = 3'd0; req_a = 16'd0; req_b = 16'd0;
    rst3 = 1'b1; req_valid3 = 1'b0; rsp_ready3 = 1'b0; of_clr3 = 1'b0;
    req_op3 = 3'd0; req_a3 = 16'd0; req_b3 = 16'd0;
    tick(); tick();
    rst = 1'b0; rst3 = 1'b0;
    #1;

    // Reset state
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_a",     {16'd0, alu_a}, 32'h0);
    chk("rst_rsp_out",   {16'd0, rsp_out}, 32'h0);
    chk("rst_op_count",  {24'd0, op_count}, 32'd0);
    chk("rst_of_sticky", {31'd0, of_sticky}, 32'd0);
    chk("rst3_req_ready", {31'd0, req_ready3}, 32'd1);

    // 1. Legal op
    tick();
    req_valid = 1'b1; req_op = 3'b000; req_a = 16'h0F00; req_b = 16'h0050;
    tick();
    req_valid = 1'b0;
    chk("t1_alu_a",     {16'd0, alu_a}, 32'h0F00);
    chk("t1_alu_b",     {16'd0, alu_b}, 32'h0050);
    chk("t1_busy",      {31'd0, busy}, 32'd1);
    chk("t1_req_ready", {31'd0, req_ready}, 32'd0);
    chk("t1_rsp_early", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_rsp_out",   {16'd0, rsp_out}, 32'h0F50);
    chk("t1_rsp_r15",   {16'd0, rsp_r15}, 32'h0000);
    chk("t1_rsp_of",    {31'd0, rsp_of}, 32'd0);
    chk("t1_rsp_err",   {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_rsp_drop",  {31'd0, rsp_valid}, 32'd0);
    chk("t1_count",     {24'd0, op_count}, 32'd1);
    chk("t1_idle",      {31'd0, req_ready}, 32'd1);

    // 2. Illegal op
    req_valid = 1'b1; req_op = 3'b111; req_a = 16'h1234; req_b = 16'hFFFF;
    tick();
    req_valid = 1'b0;
    chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t2_rsp_err",   {31'd0, rsp_err}, 32'd1);
    chk("t2_rsp_out",   {16'd0, rsp_out}, 32'h0);
    chk("t2_rsp_r15",   {16'd0, rsp_r15}, 32'h0);
    chk("t2_alu_op",    {29'd0, alu_op}, 32'd7);
    chk("t2_alu_a",     {16'd0, alu_a}, 32'h1234);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t2_count",     {24'd0, op_count}, 32'd1);

    // 3. Backpressure
    req_valid = 1'b1; req_op = 3'b001; req_a = 16'h00AA; req_b = 16'h0055;
    tick();
    req_op = 3'b010; req_a = 16'h1111; req_b = 16'h2222;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t3_hold_out",   {16'd0, rsp_out}, 32'h00FF);
      chk("t3_hold_rdy",   {31'd0, req_ready}, 32'd0);
      chk("t3_hold_alu_a", {16'd0, alu_a}, 32'h00AA);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t3_hs_drop",   {31'd0, rsp_valid}, 32'd0);
    chk("t3_not_taken", {16'd0, alu_a}, 32'h00AA);
    chk("t3_count",     {24'd0, op_count}, 32'd2);
    tick();
    req_valid = 1'b0;
    chk("t3_next_a",    {16'd0, alu_a}, 32'h1111);
    chk("t3_next_op",   {29'd0, alu_op}, 32'd2);
    tick();
    chk("t3_next_out",  {16'd0, rsp_out}, 32'h3333);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t3_count2",    {24'd0, op_count}, 32'd3);

    // 4. Overflow and sticky flag
    req_valid = 1'b1; req_op = 3'b000; req_a = 16'hFFFF; req_b = 16'h0001;
    tick();
    req_valid = 1'b0;
    chk("t4_sticky_pre", {31'd0, of_sticky}, 32'd0);
    tick();
    chk("t4_rsp_of",    {31'd0, rsp_of}, 32'd1);
    chk("t4_rsp_out",   {16'd0, rsp_out}, 32'hFFFE);
    chk("t4_rsp_r15",   {16'd0, rsp_r15}, 32'h0001);
    chk("t4_sticky",    {31'd0, of_sticky}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t4_sticky_hold", {31'd0, of_sticky}, 32'd1);
    of_clr = 1'b1;
    tick();
    of_clr = 1'b0;
    chk("t4_clr",       {31'd0, of_sticky}, 32'd0);
    req_valid = 1'b1; req_a = 16'h8000; req_b = 16'h0000;
    tick();
    req_valid = 1'b0;
    of_clr = 1'b1;
    tick();
    of_clr = 1'b0;
    chk("t4_set_wins",  {31'd0, of_sticky}, 32'd1);
    chk("t4_rsp_of2",   {31'd0, rsp_of}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t4_count",     {24'd0, op_count}, 32'd5);

    // 5. SETTLE=3 latency and mid-operation reset
    req_valid3 = 1'b1; req_op3 = 3'b011; req_a3 = 16'h00F0; req_b3 = 16'h000F;
    tick();
    req_valid3 = 1'b0;
    chk("t5_alu_a",     {16'd0, alu_a3}, 32'h00F0);
    chk("t5_c0",        {31'd0, rsp_valid3}, 32'd0);
    tick();
    chk("t5_c1",        {31'd0, rsp_valid3}, 32'd0);
    tick();
    chk("t5_c2",        {31'd0, rsp_valid3}, 32'd0);
    chk("t5_c2_busy",   {31'd0, busy3}, 32'd1);
    tick();
    chk("t5_c3_valid",  {31'd0, rsp_valid3}, 32'd1);
    chk("t5_c3_out",    {16'd0, rsp_out3}, 32'h00FF);
    rsp_ready3 = 1'b1;
    tick();
    rsp_ready3 = 1'b0;
    chk("t5_count",     {24'd0, op_count3}, 32'd1);
    req_valid3 = 1'b1; req_op3 = 3'b100; req_a3 = 16'h8001; req_b3 = 16'h0001;
    tick();
    req_valid3 = 1'b0;
    tick();
    rst3 = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, rsp_valid3}, 32'd0);
    chk("t5_rst_busy",  {31'd0, busy3}, 32'd0);
    chk("t5_rst_count", {24'd0, op_count3}, 32'd0);
    chk("t5_rst_alu_a", {16'd0, alu_a3}, 32'h0);
    #2;
    rst3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_rsp",    {31'd0, rsp_valid3}, 32'd0);
      chk("t5_no_sticky", {31'd0, of_sticky3}, 32'd0);
    end
    chk("t5_ready",     {31'd0, req_ready3}, 32'd1);

    // 6. op_count wrap: 5 done, 250 more reach 255, one more wraps to 0
    for (int i = 0; i < 250; i++) begin
      do_op(3'(i % 7), 16'(i), 16'h0101);
    end
    chk("t6_count_max", {24'd0, op_count}, 32'd255);
    do_op(3'b110, 16'h0001, 16'h0002);
    chk("t6_count_wrap", {24'd0, op_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
